// File: rtl/alert_rx_pkg.sv
// Shared types for the multi-channel alert receiver: handshake FSM states,
// differential wire bundles and the receive-side output encoder.
package alert_rx_pkg;

    typedef enum logic [1:0] {
        Idle      = 2'd0,
        HsAckWait = 2'd1,
        Pause0    = 2'd2,
        Pause1    = 2'd3
    } alert_rx_state_e;

    // Sender-to-receiver pair; alert_p is the MSB so a 2-bit slice maps directly.
    typedef struct packed {
        logic alert_p;
        logic alert_n;
    } alert_tx_t;

    // Receiver-to-sender signalling, MSB first: ping_p, ping_n, ack_p, ack_n.
    typedef struct packed {
        logic ping_p;
        logic ping_n;
        logic ack_p;
        logic ack_n;
    } alert_rx_t;

    // Both pairs are driven strictly complementary from their single-ended state.
    function automatic alert_rx_t encode_rx(input logic ping_tog, input logic ack);
        alert_rx_t rx;
        rx.ping_p = ping_tog;
        rx.ping_n = ~ping_tog;
        rx.ack_p  = ack;
        rx.ack_n  = ~ack;
        return rx;
    endfunction

endpackage

// File: rtl/alert_rx_chan.sv
// One alert receiver channel: four-phase ack handshake FSM, ping launch and
// timeout supervision, and live plus sticky signal-integrity reporting.
module alert_rx_chan
    import alert_rx_pkg::*;
#(
    parameter bit AsyncOn    = 1'b0,
    parameter int PingTimerW = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ping_en_i,
    input  logic [PingTimerW-1:0] ping_timeout_i,
    input  logic                  integ_clr_i,
    input  alert_tx_t             alert_tx_i,
    output alert_rx_t             alert_rx_o,
    output logic                  alert_o,
    output logic                  ping_ok_o,
    output logic                  ping_fail_o,
    output logic                  integ_fail_o,
    output logic                  integ_sticky_o
);

    logic                  w_level;
    logic                  w_sigint;

    alert_rx_state_e       r_state;
    alert_rx_state_e       w_state_d;
    logic                  r_ack;
    logic                  w_ack_d;
    logic                  w_alert;
    logic                  w_ping_ok;

    logic                  r_ping_en;
    logic                  r_ping_tog;
    logic                  w_ping_tog_d;
    logic                  r_pending;
    logic                  w_pending_d;
    logic [PingTimerW-1:0] r_timer;
    logic [PingTimerW-1:0] w_timer_d;
    logic                  w_ping_rise;
    logic                  w_timeout;
    logic                  w_ping_fail;

    logic                  r_sticky;
    logic                  w_sticky_d;

    prim_diff_decode #(
        .AsyncOn (AsyncOn)
    ) u_decode (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .diff_pi  (alert_tx_i.alert_p),
        .diff_ni  (alert_tx_i.alert_n),
        .level_o  (w_level),
        .sigint_o (w_sigint)
    );

    // Handshake next state; a rail fault overrides everything and parks the FSM in Idle.
    always_comb begin
        w_state_d = r_state;
        w_ack_d   = 1'b0;
        w_alert   = 1'b0;
        w_ping_ok = 1'b0;
        if (w_sigint) begin
            w_state_d = Idle;
            w_ack_d   = 1'b0;
        end else begin
            case (r_state)
                Idle: begin
                    if (w_level) begin
                        w_state_d = HsAckWait;
                        w_ack_d   = 1'b1;
                        if (r_pending) begin
                            w_ping_ok = 1'b1;
                        end else begin
                            w_alert = 1'b1;
                        end
                    end else begin
                        w_state_d = Idle;
                    end
                end
                HsAckWait: begin
                    if (!w_level) begin
                        w_state_d = Pause0;
                    end else begin
                        w_state_d = HsAckWait;
                        w_ack_d   = 1'b1;
                    end
                end
                Pause0:  w_state_d = Pause1;
                Pause1:  w_state_d = Idle;
                default: w_state_d = Idle;
            endcase
        end
    end

    // Ping launch, hold and timeout; an answer in the expiry cycle beats the fail.
    always_comb begin
        w_ping_rise  = ping_en_i & ~r_ping_en;
        w_timeout    = r_pending & (r_timer == PingTimerW'(1));
        w_ping_fail  = w_timeout & ~w_ping_ok;
        w_ping_tog_d = r_ping_tog;
        w_pending_d  = r_pending;
        w_timer_d    = r_timer;
        if (!ping_en_i) begin
            w_pending_d = 1'b0;
            w_timer_d   = '0;
        end else if (w_ping_rise) begin
            w_ping_tog_d = ~r_ping_tog;
            w_pending_d  = 1'b1;
            w_timer_d    = ping_timeout_i;
        end else if (w_ping_ok || w_timeout) begin
            w_pending_d = 1'b0;
            w_timer_d   = '0;
        end else if (r_pending && (r_timer != '0)) begin
            w_timer_d = r_timer - PingTimerW'(1);
        end else begin
            w_timer_d = r_timer;
        end
    end

    // Sticky fault bit: a fault in the same cycle as a clear keeps it set.
    always_comb begin
        w_sticky_d = w_sigint | (r_sticky & ~integ_clr_i);
    end

    // Channel state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= Idle;
            r_ack      <= 1'b0;
            r_ping_en  <= 1'b0;
            r_ping_tog <= 1'b0;
            r_pending  <= 1'b0;
            r_timer    <= '0;
            r_sticky   <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_ack      <= w_ack_d;
            r_ping_en  <= ping_en_i;
            r_ping_tog <= w_ping_tog_d;
            r_pending  <= w_pending_d;
            r_timer    <= w_timer_d;
            r_sticky   <= w_sticky_d;
        end
    end

    assign alert_rx_o     = encode_rx(r_ping_tog, r_ack);
    assign alert_o        = w_alert;
    assign ping_ok_o      = w_ping_ok;
    assign ping_fail_o    = w_ping_fail;
    assign integ_fail_o   = w_sigint;
    assign integ_sticky_o = r_sticky;

endmodule

// File: rtl/prim_diff_decode.sv
// Differential pair decoder: recovers the level from the positive rail and
// flags an integrity fault whenever both rails agree. With AsyncOn set each
// rail first passes a 2-flop synchronizer.
module prim_diff_decode #(
    parameter bit AsyncOn = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic diff_pi,
    input  logic diff_ni,
    output logic level_o,
    output logic sigint_o
);

    logic r_p_meta;
    logic r_p_sync;
    logic r_n_meta;
    logic r_n_sync;
    logic w_p;
    logic w_n;

    // Synchronizer chain, reset to the idle differential pattern (p=0, n=1).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_p_meta <= 1'b0;
            r_p_sync <= 1'b0;
            r_n_meta <= 1'b1;
            r_n_sync <= 1'b1;
        end else begin
            r_p_meta <= diff_pi;
            r_p_sync <= r_p_meta;
            r_n_meta <= diff_ni;
            r_n_sync <= r_n_meta;
        end
    end

    // The select is a constant, so the unused path is trimmed at elaboration.
    assign w_p      = AsyncOn ? r_p_sync : diff_pi;
    assign w_n      = AsyncOn ? r_n_sync : diff_ni;
    assign level_o  = w_p;
    assign sigint_o = (w_p == w_n);

endmodule

// File: rtl/alert_rx_bank.sv
// Bank of independent alert receiver channels. Unpacks the flat differential
// buses into per-channel structs and fans the sticky clear out to every channel.
module alert_rx_bank
    import alert_rx_pkg::*;
#(
    parameter int NumAlerts  = 4,
    parameter bit AsyncOn    = 1'b0,
    parameter int PingTimerW = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumAlerts-1:0]   ping_en_i,
    input  logic [PingTimerW-1:0]  ping_timeout_i,
    input  logic                   integ_clr_i,
    input  logic [2*NumAlerts-1:0] alert_tx_i,
    output logic [4*NumAlerts-1:0] alert_rx_o,
    output logic [NumAlerts-1:0]   alert_o,
    output logic [NumAlerts-1:0]   ping_ok_o,
    output logic [NumAlerts-1:0]   ping_fail_o,
    output logic [NumAlerts-1:0]   integ_fail_o,
    output logic [NumAlerts-1:0]   integ_sticky_o
);

    for (genvar gi = 0; gi < NumAlerts; gi++) begin : g_chan
        alert_tx_t w_tx;
        alert_rx_t w_rx;

        assign w_tx                 = alert_tx_t'(alert_tx_i[2*gi +: 2]);
        assign alert_rx_o[4*gi +: 4] = w_rx;

        alert_rx_chan #(
            .AsyncOn    (AsyncOn),
            .PingTimerW (PingTimerW)
        ) u_chan (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .ping_en_i      (ping_en_i[gi]),
            .ping_timeout_i (ping_timeout_i),
            .integ_clr_i    (integ_clr_i),
            .alert_tx_i     (w_tx),
            .alert_rx_o     (w_rx),
            .alert_o        (alert_o[gi]),
            .ping_ok_o      (ping_ok_o[gi]),
            .ping_fail_o    (ping_fail_o[gi]),
            .integ_fail_o   (integ_fail_o[gi]),
            .integ_sticky_o (integ_sticky_o[gi])
        );
    end

endmodule

// File: tb/tb_alert_rx_bank.sv
// Scenario bench for alert_rx_bank (4 channels, combinational decode, 8-bit
// ping timer). Each scenario queues the expected output snapshot for a cycle
// when it drives that cycle's stimulus, then pops and compares it mid-cycle.
module tb_alert_rx_bank;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [3:0]  ping_en;
    logic [7:0]  ping_timeout;
    logic        integ_clr;
    logic [7:0]  alert_tx;
    logic [15:0] alert_rx;
    logic [3:0]  alert;
    logic [3:0]  ping_ok;
    logic [3:0]  ping_fail;
    logic [3:0]  integ_fail;
    logic [3:0]  integ_sticky;

    typedef struct {
        string       tag;
        logic [35:0] v;
    } sb_item_t;

    sb_item_t sb[$];
    int       n_cmp = 0;
    int       n_mis = 0;

    wire [35:0] obs = {alert, ping_ok, ping_fail, integ_fail, integ_sticky, alert_rx};

    logic [1:0] integ_tx [12] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b01,
                                  2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01};

    alert_rx_bank #(
        .NumAlerts  (4),
        .AsyncOn    (1'b0),
        .PingTimerW (8)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .ping_en_i      (ping_en),
        .ping_timeout_i (ping_timeout),
        .integ_clr_i    (integ_clr),
        .alert_tx_i     (alert_tx),
        .alert_rx_o     (alert_rx),
        .alert_o        (alert),
        .ping_ok_o      (ping_ok),
        .ping_fail_o    (ping_fail),
        .integ_fail_o   (integ_fail),
        .integ_sticky_o (integ_sticky)
    );

    always #5 clk = ~clk;

    // Expected snapshot: pulse/level vectors plus the rx nibbles from ping toggle and ack.
    function automatic logic [35:0] mk(input logic [3:0] al, input logic [3:0] pok,
                                       input logic [3:0] pf, input logic [3:0] ig,
                                       input logic [3:0] st, input logic [3:0] tog,
                                       input logic [3:0] ack);
        logic [15:0] rx;
        for (int i = 0; i < 4; i++) begin
            rx[4*i +: 4] = {tog[i], ~tog[i], ack[i], ~ack[i]};
        end
        return {al, pok, pf, ig, st, rx};
    endfunction

    task automatic push(input string tag, input logic [35:0] v);
        sb_item_t it;
        it.tag = tag;
        it.v   = v;
        sb.push_back(it);
    endtask

    task automatic do_reset();
        rst_ni       = 1'b0;
        ping_en      = 4'b0000;
        ping_timeout = 8'd0;
        integ_clr    = 1'b0;
        alert_tx     = 8'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sb_item_t it;
        rst_ni       = 1'b0;
        ping_en      = 4'b0000;
        ping_timeout = 8'd0;
        integ_clr    = 1'b0;
        alert_tx     = 8'h55;
        #1;
        push("reset_async", mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        it = sb.pop_front();
        n_cmp++;
        if (obs !== it.v) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", it.tag, obs, it.v);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        @(negedge clk);
        push("reset_released", mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        it = sb.pop_front();
        n_cmp++;
        if (obs !== it.v) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", it.tag, obs, it.v);
        end
    endtask

    task automatic test_handshake();
        logic [7:0] lvl   = 8'b0110_0111;
        logic [7:0] e_al  = 8'b0100_0001;
        logic [7:0] e_ack = 8'b1000_1110;
        sb_item_t   it;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            alert_tx      = 8'h55;
            alert_tx[5:4] = lvl[k] ? 2'b10 : 2'b01;
            push($sformatf("handshake c%0d", k),
                 mk({1'b0, e_al[k], 2'b00}, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                    {1'b0, e_ack[k], 2'b00}));
            @(negedge clk);
            it = sb.pop_front();
            n_cmp++;
            if (obs !== it.v) begin
                n_mis++;
                $display("FAIL %s: got %h expected %h", it.tag, obs, it.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ping_answered();
        sb_item_t it;
        do_reset();
        ping_timeout = 8'd10;
        for (int k = 0; k < 15; k++) begin
            ping_en       = 4'b0001;
            alert_tx      = 8'h55;
            alert_tx[1:0] = (k == 5) ? 2'b10 : 2'b01;
            push($sformatf("ping_ok c%0d", k),
                 mk(4'h0, {3'b000, k == 5}, 4'h0, 4'h0, 4'h0,
                    {3'b000, k >= 1}, {3'b000, k == 6}));
            @(negedge clk);
            it = sb.pop_front();
            n_cmp++;
            if (obs !== it.v) begin
                n_mis++;
                $display("FAIL %s: got %h expected %h", it.tag, obs, it.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ping_timeout();
        sb_item_t it;
        do_reset();
        ping_timeout = 8'd5;
        for (int k = 0; k < 10; k++) begin
            ping_en       = 4'b0010;
            alert_tx      = 8'h55;
            alert_tx[3:2] = (k == 7) ? 2'b10 : 2'b01;
            push($sformatf("timeout5 c%0d", k),
                 mk({2'b00, k == 7, 1'b0}, 4'h0, {2'b00, k == 5, 1'b0}, 4'h0, 4'h0,
                    {2'b00, k >= 1, 1'b0}, {2'b00, k == 8, 1'b0}));
            @(negedge clk);
            it = sb.pop_front();
            n_cmp++;
            if (obs !== it.v) begin
                n_mis++;
                $display("FAIL %s: got %h expected %h", it.tag, obs, it.v);
            end
            @(posedge clk);
            #1;
        end
        // Zero timeout: never fails; dropping the enable quietly clears pending.
        do_reset();
        ping_timeout = 8'd0;
        for (int k = 0; k < 275; k++) begin
            ping_en       = (k < 270) ? 4'b0010 : 4'b0000;
            alert_tx      = 8'h55;
            alert_tx[3:2] = (k == 272) ? 2'b10 : 2'b01;
            push($sformatf("timeout0 c%0d", k),
                 mk({2'b00, k == 272, 1'b0}, 4'h0, 4'h0, 4'h0, 4'h0,
                    {2'b00, k >= 1, 1'b0}, {2'b00, k == 273, 1'b0}));
            @(negedge clk);
            it = sb.pop_front();
            n_cmp++;
            if (obs !== it.v) begin
                n_mis++;
                $display("FAIL %s: got %h expected %h", it.tag, obs, it.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_integrity();
        logic [11:0] clr  = 12'h540;
        logic [11:0] e_st = 12'h67C;
        logic [11:0] e_al = 12'h011;
        logic [11:0] e_ig = 12'h106;
        logic [11:0] e_ak = 12'h022;
        sb_item_t    it;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            alert_tx      = 8'h55;
            alert_tx[7:6] = integ_tx[k];
            integ_clr     = clr[k];
            push($sformatf("integrity c%0d", k),
                 mk({e_al[k], 3'b000}, 4'h0, 4'h0, {e_ig[k], 3'b000}, {e_st[k], 3'b000},
                    4'h0, {e_ak[k], 3'b000}));
            @(negedge clk);
            it = sb.pop_front();
            n_cmp++;
            if (obs !== it.v) begin
                n_mis++;
                $display("FAIL %s: got %h expected %h", it.tag, obs, it.v);
            end
            @(posedge clk);
            #1;
        end
        integ_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        sb_item_t it;
        do_reset();
        ping_timeout = 8'd3;
        for (int k = 0; k < 9; k++) begin
            ping_en       = 4'b0101;
            alert_tx      = 8'h55;
            alert_tx[1:0] = (k == 3) ? 2'b10 : 2'b01;
            alert_tx[5:4] = (k >= 2 && k <= 6) ? 2'b11 : 2'b01;
            push($sformatf("same_cycle c%0d", k),
                 mk(4'h0, {3'b000, k == 3}, {1'b0, k == 3, 2'b00},
                    {1'b0, k >= 2 && k <= 6, 2'b00}, {1'b0, k >= 3, 2'b00},
                    {1'b0, k >= 1, 1'b0, k >= 1}, {3'b000, k == 4}));
            @(negedge clk);
            it = sb.pop_front();
            n_cmp++;
            if (obs !== it.v) begin
                n_mis++;
                $display("FAIL %s: got %h expected %h", it.tag, obs, it.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_op();
        sb_item_t it;
        do_reset();
        ping_timeout = 8'd20;
        for (int k = 0; k < 3; k++) begin
            ping_en       = 4'b0010;
            alert_tx      = 8'h55;
            alert_tx[1:0] = 2'b10;
            push($sformatf("pre_reset c%0d", k),
                 mk({3'b000, k == 0}, 4'h0, 4'h0, 4'h0, 4'h0,
                    {2'b00, k >= 1, 1'b0}, {3'b000, k >= 1}));
            @(negedge clk);
            it = sb.pop_front();
            n_cmp++;
            if (obs !== it.v) begin
                n_mis++;
                $display("FAIL %s: got %h expected %h", it.tag, obs, it.v);
            end
            if (k < 2) begin
                @(posedge clk);
                #1;
            end else begin
                #2;
            end
        end
        rst_ni   = 1'b0;
        alert_tx = 8'h55;
        #1;
        for (int k = 0; k < 2; k++) begin
            push($sformatf("mid_reset s%0d", k), mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
            it = sb.pop_front();
            n_cmp++;
            if (obs !== it.v) begin
                n_mis++;
                $display("FAIL %s: got %h expected %h", it.tag, obs, it.v);
            end
            @(posedge clk);
            #1;
        end
        ping_en = 4'b0000;
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_ping_answered();
        test_ping_timeout();
        test_integrity();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
